reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   MIPS-style 32-entry x 32-bit general-purpose register file: two asynchronous
//   read ports, one synchronous write port. Register 0 is hard-wired to zero.
//   Sits in the CPU datapath between instruction decode (rs/rt/rd numbers) and
//   the ALU/writeback stage.
// PARAMETERS
//   DATA_W  32  register width in bits (fixed; no other value required)
//   ADDR_W  5   register-number width; 2**ADDR_W = 32 entries
// PORTS
//   clk     in   1       single clock; all writes on the rising edge
//   reset   in   1       asynchronous, active-high; clears r1..r31
//   reg1n   in   5       read port 1 register number
//   reg2n   in   5       read port 2 register number
//   reg1o   out  32      read port 1 data = R[reg1n]
//   reg2o   out  32      read port 2 data = R[reg2n]
//   wregn   in   5       write register number
//   wdata   in   32      write data
//   wen     in   1       write enable
// BEHAVIOUR
//   - Reset: while reset=1, r1..r31 = 0 immediately (no clock needed); reset
//     dominates wen and any clock edge. Outputs during reset = 0 for any address.
//   - Write: at posedge clk with reset=0 and wen=1, R[wregn] <= wdata. Exactly
//     one register is written; all others hold. wen=0 -> no register changes.
//   - r0: reads always return 32'h0; writes to wregn=0 are discarded silently.
//   - Read: purely combinational, zero latency; reg1o/reg2o follow reg1n/reg2n
//     and register contents within the same cycle. Both ports independent; both
//     may address the same register.
//   - Read-during-write: no bypass. A read of R[wregn] in the write cycle returns
//     the old value until the rising edge, then the new value.
//   - Back-to-back writes to successive registers every cycle are supported.
//   - No X propagation from unused paths: every address 0..31 decodes to a
//     defined value; the write decoder is one-hot or all-zero.
// STRUCTURE
//   - Shared package: DATA_W, ADDR_W, NUM_REGS=32, ZERO_REG=5'd0.
//   - Write decode: 2-to-4 one-hot demux on wregn[4:3] gated by wen, each output
//     enabling a 3-to-8 one-hot demux on wregn[2:0] -> 32 write enables
//     (enable[0] unused).
//   - Storage: 31 instances of one sub-module reg32 (32-bit flop with enable
//     and async active-high clear); slot 0 is the constant zero.
//   - Read select: two instances of a 32-input x 32-bit mux (mux32x32) selected
//     by reg1n / reg2n.
// TESTING
//   1. Pulse reset mid-simulation with all registers previously written ->
//      reg1o=reg2o=0 for all addresses 0..31, before any clock edge.
//   2. wen=1, write R[i]=i for i=1..31 one per cycle; then wen=0, sweep
//      reg1n=reg2n=0..31 -> both ports return i (0 for r0).
//   3. wen=1, wregn=0, wdata=32'hFFFF_FFFF, clock -> reg1n=0 reads 0.
//   4. wen=0, wregn=5, wdata=32'hDEAD_BEEF, clock -> R5 keeps its prior value.
//   5. Read R7 on port 1 while writing 32'h1234_5678 to R7 -> old value before
//      the edge, 32'h1234_5678 after; port 2 on R8 unchanged throughout.
//   6. Assert reset coincident with wen=1 write of R3 -> R3 reads 0 after the
//      edge.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths, register-file geometry and the one-hot decode helpers used by
// the register file and its storage/read sub-blocks.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned GRP_W    = 2;
  localparam int unsigned SUB_W    = 3;
  localparam int unsigned NUM_GRPS = 4;
  localparam int unsigned GRP_SIZE = 8;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  // Gated 2-to-4 one-hot demux; all-zero when disabled.
  function automatic logic [NUM_GRPS-1:0] demux_2to4(input logic en,
                                                     input logic [GRP_W-1:0] sel);
    logic [NUM_GRPS-1:0] r;
    r = '0;
    if (en) begin
      r[sel] = 1'b1;
    end
    return r;
  endfunction

  // Ungated 3-to-8 one-hot demux; qualified later by the group enable.
  function automatic logic [GRP_SIZE-1:0] demux_3to8(input logic [SUB_W-1:0] sel);
    logic [GRP_SIZE-1:0] r;
    r = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_mux32x32.sv
// 32-input x 32-bit combinational read multiplexer over a flattened bus.
module mux32x32
  import reg_file_pkg::*;
(
  input  logic [NUM_REGS*DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0]          i_sel,
  output logic [DATA_W-1:0]          o_data
);

  // Every select value matches exactly one slot, so the output is always defined.
  always_comb begin
    o_data = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (i_sel == ADDR_W'(k)) begin
        o_data = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_file_reg32.sv
// One 32-bit register with write enable and asynchronous active-high clear.
module reg32
  import reg_file_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_file.sv
// MIPS-style 32x32 register file: two asynchronous read ports, one synchronous
// write port, r0 hard-wired to zero, asynchronous active-high clear of r1..r31.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reg1n,
  input  logic [ADDR_W-1:0] reg2n,
  output logic [DATA_W-1:0] reg1o,
  output logic [DATA_W-1:0] reg2o,
  input  logic [ADDR_W-1:0] wregn,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen
);

  logic [NUM_GRPS-1:0]        w_grp_en;
  logic [GRP_SIZE-1:0]        w_sub_en;
  logic [NUM_REGS*DATA_W-1:0] w_rd_bus;

  // Two-level write decode: upper bits pick a bank of eight, lower bits the slot.
  assign w_grp_en = demux_2to4(wen, wregn[ADDR_W-1 -: GRP_W]);
  assign w_sub_en = demux_3to8(wregn[SUB_W-1:0]);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    if (ADDR_W'(i) == ZERO_REG) begin : g_zero
      assign w_rd_bus[i*DATA_W +: DATA_W] = '0;
    end else begin : g_reg
      logic w_wen;
      assign w_wen = w_grp_en[i / GRP_SIZE] & w_sub_en[i % GRP_SIZE];

      reg32 u_reg (
        .i_clk (clk),
        .i_clr (reset),
        .i_en  (w_wen),
        .i_d   (wdata),
        .o_q   (w_rd_bus[i*DATA_W +: DATA_W])
      );
    end
  end

  mux32x32 u_rd1 (
    .i_data (w_rd_bus),
    .i_sel  (reg1n),
    .o_data (reg1o)
  );

  mux32x32 u_rd2 (
    .i_data (w_rd_bus),
    .i_sel  (reg2n),
    .o_data (reg2o)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array model of the register file, compared
// before and after every clock edge, plus pinned literal expectations.
module tb_reg_file;

  logic        clk;
  logic        clk_run;
  logic        reset;
  logic [4:0]  reg1n, reg2n, wregn;
  logic [31:0] reg1o, reg2o, wdata;
  logic        wen;

  logic [31:0] model [32];
  int          n_checks;
  int          n_errors;

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .reg1n (reg1n),
    .reg2n (reg2n),
    .reg1o (reg1o),
    .reg2o (reg2o),
    .wregn (wregn),
    .wdata (wdata),
    .wen   (wen)
  );

  // Gateable clock so the reset test can run with no edges at all.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic [31:0] expv(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) model[k] = 32'h0;
  endtask

  task automatic compare(input string tag);
    check({tag, " port1"}, reg1o, expv(reg1n));
    check({tag, " port2"}, reg2o, expv(reg2n));
  endtask

  // One cycle: drive, compare before the edge, apply model write, compare after.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2);
    wen = w; wregn = wa; wdata = wd; reg1n = a1; reg2n = a2;
    @(negedge clk);
    compare("pre-edge");
    @(posedge clk);
    if (reset) clear_model();
    else if (w && wa != 5'd0) model[wa] = wd;
    #1;
    compare("post-edge");
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    clk = 1'b0; clk_run = 1'b1;
    reset = 1'b1; wen = 1'b0; wregn = '0; wdata = '0; reg1n = '0; reg2n = '0;
    clear_model();

    // Reset state
    #1;
    reg1n = 5'd1; reg2n = 5'd31; #1;
    check("reset state r1", reg1o, 32'h0);
    check("reset state r31", reg2o, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Write R[i]=i back to back, then sweep both ports
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i), 5'($urandom), 5'($urandom));
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 5'($urandom), $urandom, 5'(a), 5'(a));
      check("sweep port1 literal", reg1o, 32'(a));
      check("sweep port2 literal", reg2o, 32'(a));
    end

    // Writes to r0 are discarded
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    check("r0 write discarded", reg1o, 32'h0);

    // wen=0 leaves R5 alone
    step(1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
    check("wen low keeps r5", reg1o, 32'd5);

    // Read-during-write on R7 with R8 on the other port
    wen = 1'b1; wregn = 5'd7; wdata = 32'h1234_5678; reg1n = 5'd7; reg2n = 5'd8;
    @(negedge clk);
    check("rdw r7 before edge", reg1o, 32'd7);
    check("rdw r8 before edge", reg2o, 32'd8);
    compare("rdw pre-edge");
    @(posedge clk);
    model[7] = 32'h1234_5678;
    #1;
    check("rdw r7 after edge", reg1o, 32'h1234_5678);
    check("rdw r8 after edge", reg2o, 32'd8);
    compare("rdw post-edge");

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom,
           5'($urandom), 5'($urandom));
    end

    // Asynchronous reset with the clock stopped: every address reads zero
    @(negedge clk);
    clk_run = 1'b0;
    check("rand-written r7 before reset", reg1o, expv(reg1n));
    reset = 1'b1;
    clear_model();
    for (int a = 0; a < 32; a++) begin
      reg1n = 5'(a); reg2n = 5'(31 - a);
      #1;
      check("async reset port1", reg1o, 32'h0);
      check("async reset port2", reg2o, 32'h0);
    end
    reset = 1'b0;
    #1;
    clk_run = 1'b1;
    @(posedge clk); #1;

    // Reset coincident with a write of R3
    step(1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd3);
    check("r3 written before reset test", reg1o, 32'h0000_0033);
    reset = 1'b1; wen = 1'b1; wregn = 5'd3; wdata = 32'hAAAA_5555; reg1n = 5'd3; reg2n = 5'd3;
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0; wen = 1'b0;
    #1;
    check("reset beats write r3", reg1o, 32'h0);
    compare("after reset+write");

    // A little more traffic after reset
    for (int n = 0; n < 40; n++) begin
      step(1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the sequence above is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
